// File: rtl/mem_access_unit.sv
// Load/store initiator for the main memory data port: byte/word accesses,
// lane masking on stores, aligned sign/zero-extended load data.
module mem_access_unit #(
    parameter int unsigned A_WIDTH = 13
) (
    input  logic               clk,
    input  logic               rst_async_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic               req_byte,
    input  logic               req_signed,
    input  logic [15:0]        req_addr,
    input  logic [15:0]        req_wdata,
    output logic               resp_valid,
    output logic               resp_err,
    output logic [15:0]        resp_rdata,
    output logic [A_WIDTH-1:0] mem_data_addr,
    input  logic [15:0]        mem_data_read,
    output logic               mem_data_write_en,
    output logic [1:0]         mem_data_write_mask,
    output logic [15:0]        mem_data_write
);

    typedef enum logic [1:0] {IDLE, LOAD, RESP} state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] waddr_q, waddr_d;
    logic               lane_q, lane_d;
    logic               byte_q, byte_d;
    logic               signed_q, signed_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               hs;
    logic               misaligned;
    logic               store_go;
    logic [7:0]         ld_byte;

    assign hs         = req_valid && (state_q == IDLE);
    assign misaligned = !req_byte && req_addr[0];
    // Gated by reset so no store can leak out while reset is held.
    assign store_go   = rst_async_n && hs && req_write && !misaligned;

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state_q  <= IDLE;
            waddr_q  <= '0;
            lane_q   <= 1'b0;
            byte_q   <= 1'b0;
            signed_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            waddr_q  <= waddr_d;
            lane_q   <= lane_d;
            byte_q   <= byte_d;
            signed_q <= signed_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        lane_d   = lane_q;
        byte_d   = byte_q;
        signed_d = signed_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        ld_byte  = lane_q ? mem_data_read[15:8] : mem_data_read[7:0];
        case (state_q)
            IDLE: begin
                if (hs) begin
                    waddr_d  = req_addr[A_WIDTH:1];
                    lane_d   = req_addr[0];
                    byte_d   = req_byte;
                    signed_d = req_signed;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else if (req_write) begin
                        err_d   = 1'b0;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                err_d   = 1'b0;
                rdata_d = byte_q ? {{8{ld_byte[7] & signed_q}}, ld_byte} : mem_data_read;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready           = (state_q == IDLE);
    assign resp_valid          = (state_q == RESP);
    assign resp_err            = err_q;
    assign resp_rdata          = rdata_q;
    assign mem_data_addr       = (state_q == IDLE) ? req_addr[A_WIDTH:1] : waddr_q;
    assign mem_data_write_en   = store_go;
    assign mem_data_write_mask = !store_go ? 2'b00 :
                                 !req_byte ? 2'b11 :
                                 (req_addr[0] ? 2'b10 : 2'b01);
    assign mem_data_write      = !store_go ? 16'h0000 :
                                 req_byte ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata;

endmodule
